// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package cpu_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IMEM,
      ST_DLO,
      ST_DHI,
      ST_CHK,
      ST_RUN,
      ST_ERR
   } state_e;

   localparam int CNT_W = 16;

   localparam int HDR_NI_LSB = 0;
   localparam int HDR_NI_MSB = 15;
   localparam int HDR_ND_LSB = 16;
   localparam int HDR_ND_MSB = 31;

   localparam int unsigned IMEM_STRIDE = 4;
   localparam int unsigned DMEM_STRIDE = 8;

endpackage

// File: rtl/loader_word_counter.sv
// 16-bit load/decrement counter; zero_o flags that the current item is the last one
// when the counter is loaded with (count - 1).
module loader_word_counter
   import cpu_loader_pkg::*;
(
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_loader.sv
// Streams a boot image into the CPU instruction/data memories, then enables execution.
// Optional trailing checksum word is enabled with the macro CPU_LOADER_CHECKSUM_EN.
module cpu_loader
   import cpu_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        err
);

   localparam logic [CNT_W:0] IMEM_MAX = (CNT_W+1)'(IMEM_DEPTH);
   localparam logic [CNT_W:0] DMEM_MAX = (CNT_W+1)'(DMEM_DEPTH);
`ifdef CPU_LOADER_CHECKSUM_EN
   localparam state_e ST_FINAL = ST_CHK;
`else
   localparam state_e ST_FINAL = ST_RUN;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             nd_pend_q, nd_pend_d;
   logic [31:0]      lo_q, lo_d;
   logic [63:0]      addr_i_q, addr_i_d;
   logic             wen_i_q, wen_i_d;
   logic [31:0]      wdata_i_q, wdata_i_d;
   logic [63:0]      addr_d_q, addr_d_d;
   logic             wen_d_q, wen_d_d;
   logic [63:0]      wdata_d_q, wdata_d_d;
`ifdef CPU_LOADER_CHECKSUM_EN
   logic [31:0]      sum_q, sum_d;
`endif

   logic             xfer;
   logic [CNT_W-1:0] hdr_ni, hdr_nd;
   logic             hdr_xfer, ni_last, nd_last;

   assign xfer     = s_valid && s_ready;
   assign hdr_ni   = s_data[HDR_NI_MSB:HDR_NI_LSB];
   assign hdr_nd   = s_data[HDR_ND_MSB:HDR_ND_LSB];
   assign hdr_xfer = xfer && (state_q == ST_IDLE);

   // Counters hold (remaining - 1) so the zero flag marks the final item of each section.
   loader_word_counter u_ni_cnt (
      .clk        (clk),
      .arst_n     (arst_n),
      .load_i     (hdr_xfer),
      .load_val_i (hdr_ni - CNT_W'(1)),
      .dec_i      (xfer && (state_q == ST_IMEM)),
      .zero_o     (ni_last)
   );

   loader_word_counter u_nd_cnt (
      .clk        (clk),
      .arst_n     (arst_n),
      .load_i     (hdr_xfer),
      .load_val_i (hdr_nd - CNT_W'(1)),
      .dec_i      (xfer && (state_q == ST_DHI)),
      .zero_o     (nd_last)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      nd_pend_d = nd_pend_q;
      lo_d      = lo_q;
      addr_i_d  = addr_i_q;
      wen_i_d   = 1'b0;
      wdata_i_d = wdata_i_q;
      addr_d_d  = addr_d_q;
      wen_d_d   = 1'b0;
      wdata_d_d = wdata_d_q;
`ifdef CPU_LOADER_CHECKSUM_EN
      sum_d     = xfer ? (sum_q + s_data) : sum_q;
`endif
      unique case (state_q)
         ST_IDLE: if (xfer) begin
            idx_d     = '0;
            nd_pend_d = (hdr_nd != '0);
            if (({1'b0, hdr_ni} > IMEM_MAX) || ({1'b0, hdr_nd} > DMEM_MAX)) begin
               state_d = ST_ERR;
            end else if (hdr_ni != '0) begin
               state_d = ST_IMEM;
            end else if (hdr_nd != '0) begin
               state_d = ST_DLO;
            end else begin
               state_d = ST_FINAL;
            end
         end
         ST_IMEM: if (xfer) begin
            wen_i_d   = 1'b1;
            addr_i_d  = 64'(idx_q) * 64'(IMEM_STRIDE);
            wdata_i_d = s_data;
            idx_d     = idx_q + CNT_W'(1);
            if (ni_last) begin
               idx_d   = '0;
               state_d = nd_pend_q ? ST_DLO : ST_FINAL;
            end
         end
         ST_DLO: if (xfer) begin
            lo_d    = s_data;
            state_d = ST_DHI;
         end
         ST_DHI: if (xfer) begin
            wen_d_d   = 1'b1;
            addr_d_d  = 64'(idx_q) * 64'(DMEM_STRIDE);
            wdata_d_d = {s_data, lo_q};
            idx_d     = idx_q + CNT_W'(1);
            state_d   = nd_last ? ST_FINAL : ST_DLO;
         end
`ifdef CPU_LOADER_CHECKSUM_EN
         ST_CHK: if (xfer) begin
            state_d = (s_data == sum_q) ? ST_RUN : ST_ERR;
         end
`endif
         ST_RUN:  state_d = ST_RUN;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         nd_pend_q <= 1'b0;
         lo_q      <= '0;
         addr_i_q  <= '0;
         wen_i_q   <= 1'b0;
         wdata_i_q <= '0;
         addr_d_q  <= '0;
         wen_d_q   <= 1'b0;
         wdata_d_q <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         nd_pend_q <= nd_pend_d;
         lo_q      <= lo_d;
         addr_i_q  <= addr_i_d;
         wen_i_q   <= wen_i_d;
         wdata_i_q <= wdata_i_d;
         addr_d_q  <= addr_d_d;
         wen_d_q   <= wen_d_d;
         wdata_d_q <= wdata_d_d;
`ifdef CPU_LOADER_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign s_ready     = state_q inside {ST_IDLE, ST_IMEM, ST_DLO, ST_DHI, ST_CHK};
   assign busy        = state_q inside {ST_IMEM, ST_DLO, ST_DHI, ST_CHK};
   assign err         = (state_q == ST_ERR);
   // Hold enable off while the final write pulse is still on the memory port.
   assign cpu_enable  = (state_q == ST_RUN) && !wen_i_q && !wen_d_q;
   assign addr_ext    = addr_i_q;
   assign wen_ext     = wen_i_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_i_q;
   assign addr_ext_2  = addr_d_q;
   assign wen_ext_2   = wen_d_q;
   assign ren_ext_2   = 1'b0;
   assign wdata_ext_2 = wdata_d_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: stimulus pushes expected writes, a monitor pops and compares.
module tb_cpu_loader;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        err;

   cpu_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        port;
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         e_wr, g_wr;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_wr_cyc = -1;
   int          rise_cyc = -1;
   int          sent_cyc = 0;
   int          n_wen_i = 0;
   logic        en_prev = 1'b0;
   logic [31:0] tb_sum = 32'h0;

`ifdef CPU_LOADER_CHECKSUM_EN
   localparam int CHK_OFS = 1;
`else
   localparam int CHK_OFS = 0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (wen_ext && wen_ext_2) begin
         checks++;
         errors++;
         $display("FAIL both_wen got=1 exp=0 at cyc %0d", cyc);
      end
      if (wen_ext || wen_ext_2) begin
         last_wr_cyc = cyc;
         if (wen_ext) begin
            n_wen_i++;
            g_wr = '{port: 1'b0, addr: addr_ext, data: {32'h0, wdata_ext}};
         end else begin
            g_wr = '{port: 1'b1, addr: addr_ext_2, data: wdata_ext_2};
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got port=%0d addr=%h data=%h exp=none",
                     g_wr.port, g_wr.addr, g_wr.data);
         end else begin
            e_wr = exp_q.pop_front();
            if (g_wr !== e_wr) begin
               errors++;
               $display("FAIL write got port=%0d addr=%h data=%h exp port=%0d addr=%h data=%h",
                        g_wr.port, g_wr.addr, g_wr.data, e_wr.port, e_wr.addr, e_wr.data);
            end
         end
      end
      if (cpu_enable && !en_prev) rise_cyc = cyc;
      en_prev = cpu_enable;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic port, input logic [63:0] addr, input logic [63:0] data);
      exp_q.push_back('{port: port, addr: addr, data: data});
   endtask

   // Called at posedge+1; leaves at posedge+1 after the word was accepted.
   task automatic send(input logic [31:0] w, input int gap);
      s_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      s_valid  = 1'b1;
      s_data   = w;
      tb_sum   = tb_sum + w;
      sent_cyc = cyc;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic finish_image(input logic bad);
`ifdef CPU_LOADER_CHECKSUM_EN
      logic [31:0] cs;
      cs = tb_sum ^ {31'h0, bad};
      send(cs, 0);
`else
      if (bad) $display("note: checksum disabled, corruption request ignored");
`endif
   endtask

   task automatic wait_en(input string name);
      int n = 0;
      while (!cpu_enable && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!cpu_enable) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got cpu_enable=0 exp=1", name);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string p);
      chk1({p, "_s_ready"}, s_ready, 1'b1);
      chk1({p, "_wen_ext"}, wen_ext, 1'b0);
      chk1({p, "_wen_ext_2"}, wen_ext_2, 1'b0);
      chk1({p, "_ren"}, ren_ext | ren_ext_2, 1'b0);
      chk64({p, "_addr_ext"}, addr_ext, 64'h0);
      chk64({p, "_wdata_ext"}, {32'h0, wdata_ext}, 64'h0);
      chk64({p, "_addr_ext_2"}, addr_ext_2, 64'h0);
      chk64({p, "_wdata_ext_2"}, wdata_ext_2, 64'h0);
      chk1({p, "_cpu_enable"}, cpu_enable, 1'b0);
      chk1({p, "_busy"}, busy, 1'b0);
      chk1({p, "_err"}, err, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      arst_n      = 1'b0;
      s_valid     = 1'b0;
      tb_sum      = 32'h0;
      n_wen_i     = 0;
      rise_cyc    = -1;
      last_wr_cyc = -1;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_first_image(input logic bad);
      push_wr(1'b0, 64'h0, 64'h0000_0000_0000_0013);
      push_wr(1'b0, 64'h4, 64'h0000_0000_00A0_0093);
      push_wr(1'b1, 64'h0, 64'h0123_4567_DEAD_BEEF);
      send(32'h0001_0002, 0);
      send(32'h0000_0013, 0);
      send(32'h00A0_0093, 0);
      send(32'hDEAD_BEEF, 0);
      send(32'h0123_4567, 0);
      finish_image(bad);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n  = 1'b0;
      s_valid = 1'b0;
      s_data  = 32'h0;
      @(posedge clk);
      #1;
      chk_reset_vals("rst");
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      // Scenario 1: two instruction words and one dword
      run_first_image(1'b0);
      wait_en("s1");
      chk1("s1_cpu_enable", cpu_enable, 1'b1);
      chk1("s1_busy", busy, 1'b0);
      chk1("s1_s_ready", s_ready, 1'b0);
      chki("s1_en_timing", rise_cyc, last_wr_cyc + 1);
      chki("s1_queue_empty", exp_q.size(), 0);

      // Scenario 2: empty image
      do_reset();
      send(32'h0000_0000, 0);
      finish_image(1'b0);
      wait_en("s2");
      chki("s2_en_timing", rise_cyc, sent_cyc + 1 - CHK_OFS);
      chki("s2_no_writes", last_wr_cyc, -1);

      // Scenario 3: oversized instruction count
      do_reset();
      send(32'h0000_0201, 0);
      chk1("s3_err", err, 1'b1);
      chk1("s3_s_ready", s_ready, 1'b0);
      chk1("s3_busy", busy, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      chk1("s3_err_sticky", err, 1'b1);
      chk1("s3_cpu_enable", cpu_enable, 1'b0);
      chki("s3_no_writes", last_wr_cyc, -1);

      // Scenario 4: 16 words with random valid gaps
      do_reset();
      send(32'h0000_0010, 0);
      for (int i = 0; i < 16; i++) begin
         push_wr(1'b0, 64'(4 * i), 64'(32'hA500_0000 + 32'(i)));
         send(32'hA500_0000 + 32'(i), int'($urandom_range(0, 3)));
      end
      finish_image(1'b0);
      wait_en("s4");
      chki("s4_wen_count", n_wen_i, 16);
      chki("s4_queue_empty", exp_q.size(), 0);

      // Scenario 5: reset after 3 of 8 words, then a clean reload
      do_reset();
      send(32'h0000_0008, 0);
      for (int i = 0; i < 3; i++) begin
         push_wr(1'b0, 64'(4 * i), 64'(32'h5000_0000 + 32'(i)));
         send(32'h5000_0000 + 32'(i), 0);
      end
      chk1("s5_busy_mid", busy, 1'b1);
      @(posedge clk);
      #1;
      chki("s5_partial_drained", exp_q.size(), 0);
      arst_n = 1'b0;
      #1;
      chk_reset_vals("s5_rst");
      do_reset();
      send(32'h0000_0008, 0);
      for (int i = 0; i < 8; i++) begin
         push_wr(1'b0, 64'(4 * i), 64'(32'h6000_0000 + 32'(i)));
         send(32'h6000_0000 + 32'(i), 0);
      end
      finish_image(1'b0);
      wait_en("s5");
      chki("s5_wen_count", n_wen_i, 8);
      chki("s5_queue_empty", exp_q.size(), 0);

`ifdef CPU_LOADER_CHECKSUM_EN
      // Scenario 6: bad checksum ends in ERR with no enable
      do_reset();
      run_first_image(1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk1("s6_err", err, 1'b1);
      chk1("s6_cpu_enable", cpu_enable, 1'b0);
      chki("s6_never_enabled", rise_cyc, -1);
      chki("s6_queue_empty", exp_q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
